// File: rtl/gpr_regfile_mp.sv
// rtl/gpr_regfile_mp.sv - multi-read-port GPR file with byte-lane writes, write-through bypass and a clear engine
// Clears the whole file after reset and one thread on request; external writes are ignored while clearing.
module gpr_regfile_mp #(
    parameter int WID         = 32,
    parameter int NTHR        = 4,
    parameter int NREG        = 64,
    parameter int NRD         = 3,
    parameter bit ZERO_BYPASS = 1'b1,
    localparam int RW         = $clog2(NREG),
    localparam int TW         = (NTHR > 1) ? $clog2(NTHR) : 1,
    localparam int AW         = TW + RW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WID/8-1:0]   wr,
    input  logic [AW-1:0]      wa,
    input  logic [WID-1:0]     i,
    input  logic [NRD*AW-1:0]  ra,
    output logic [NRD*WID-1:0] o,
    input  logic               clr_req,
    input  logic [TW-1:0]      clr_tid,
    output logic               busy
);

    localparam int NB    = WID / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_ALL = AW'(NTHR * NREG - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ALL = 2'd1,
        CLR_THR = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tid_q, tid_d;
    logic [NB-1:0]        we;
    logic [AW-1:0]        waddr;
    logic [WID-1:0]       wdata;
    logic [WID-1:0]       mem [DEPTH];
    logic [NRD*WID-1:0]   o_q, o_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ALL;
            cnt_q   <= '0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
        end
    end

    // The clear engine owns the single write port whenever it is active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tid_d   = tid_q;
        we      = '0;
        waddr   = wa;
        wdata   = i;
        case (state_q)
            IDLE: begin
                we = wr;
                if (clr_req) begin
                    state_d = CLR_THR;
                    tid_d   = clr_tid;
                    cnt_d   = '0;
                end
            end
            CLR_ALL: begin
                we    = '1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_ALL) state_d = IDLE;
            end
            CLR_THR: begin
                we    = '1;
                waddr = {tid_q, cnt_q[RW-1:0]};
                wdata = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q[RW-1:0] == {RW{1'b1}}) state_d = IDLE;
            end
            default: state_d = CLR_ALL;
        endcase
        if (rst) we = '0;
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Each port sees the array as it stands after this edge's write, merged byte by byte.
    always_comb begin
        o_d = '0;
        for (int k = 0; k < NRD; k++) begin
            o_d[k*WID +: WID] = mem[ra[k*AW +: AW]];
            for (int b = 0; b < NB; b++) begin
                if (we[b] && (waddr == ra[k*AW +: AW]))
                    o_d[k*WID + 8*b +: 8] = wdata[8*b +: 8];
            end
            if (ZERO_BYPASS && (ra[k*AW +: RW] == '0))
                o_d[k*WID +: WID] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) o_q <= '0;
        else     o_q <= o_d;
    end

    assign o = o_q;

endmodule

// File: tb/tb_gpr_regfile_mp.sv
// tb/tb_gpr_regfile_mp.sv - randomized and directed checks of gpr_regfile_mp against an array/queue reference model
module tb_gpr_regfile_mp;

    localparam int WID = 32, NTHR = 4, NREG = 64, NRD = 3;
    localparam int RW = 6, TW = 2, AW = 8, NE = NTHR * NREG, NB = WID / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NB-1:0]      wr;
    logic [AW-1:0]      wa;
    logic [WID-1:0]     i;
    logic [NRD*AW-1:0]  ra;
    logic [NRD*WID-1:0] o, o_nz;
    logic               clr_req;
    logic [TW-1:0]      clr_tid;
    logic               busy, busy_nz;

    always #5 clk = ~clk;

    gpr_regfile_mp #(.WID(WID), .NTHR(NTHR), .NREG(NREG), .NRD(NRD), .ZERO_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wa(wa), .i(i), .ra(ra), .o(o),
        .clr_req(clr_req), .clr_tid(clr_tid), .busy(busy)
    );

    gpr_regfile_mp #(.WID(WID), .NTHR(NTHR), .NREG(NREG), .NRD(NRD), .ZERO_BYPASS(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .wr(wr), .wa(wa), .i(i), .ra(ra), .o(o_nz),
        .clr_req(clr_req), .clr_tid(clr_tid), .busy(busy_nz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain array plus a queue of addresses still to be zeroed.
    logic [WID-1:0] m [NE];
    int             clr_q[$];
    bit             init_done = 1'b0;
    bit             chk_o = 1'b0;
    logic [WID-1:0] eo [NRD];
    logic [WID-1:0] eo_nz [NRD];

    task automatic model_edge();
        int a;
        if (rst) begin
            clr_q.delete();
            for (int n = 0; n < NE; n++) clr_q.push_back(n);
            for (int k = 0; k < NRD; k++) begin
                eo[k]    = '0;
                eo_nz[k] = '0;
            end
            chk_o = 1'b1;
            return;
        end
        if (clr_q.size() != 0) begin
            a    = clr_q.pop_front();
            m[a] = '0;
            if (clr_q.size() == 0) init_done = 1'b1;
        end else begin
            for (int b = 0; b < NB; b++)
                if (wr[b]) m[int'(wa)][8*b +: 8] = i[8*b +: 8];
            if (clr_req)
                for (int r = 0; r < NREG; r++) clr_q.push_back(int'(clr_tid) * NREG + r);
        end
        for (int k = 0; k < NRD; k++) begin
            a        = int'(ra[k*AW +: AW]);
            eo_nz[k] = m[a];
            eo[k]    = (a % NREG == 0) ? '0 : m[a];
        end
        chk_o = init_done;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {63'd0, busy}, {63'd0, clr_q.size() != 0});
        check("busy_nz", {63'd0, busy_nz}, {63'd0, clr_q.size() != 0});
        if (chk_o) begin
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("o%0d", k), {32'd0, o[k*WID +: WID]}, {32'd0, eo[k]});
                check($sformatf("o%0d_nz", k), {32'd0, o_nz[k*WID +: WID]}, {32'd0, eo_nz[k]});
            end
        end
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra[0*AW +: AW] = AW'(a0);
        ra[1*AW +: AW] = AW'(a1);
        ra[2*AW +: AW] = AW'(a2);
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; wr = '0; wa = '0; i = '0; ra = '0; clr_req = 1'b0; clr_tid = '0;

        // Reset and full clear
        repeat (2) tick();
        check("rst_o", 64'(o), 64'd0);
        rst = 1'b0;
        count_busy("busy_len_all", NE);
        for (int a = 0; a < NE; a++) begin
            set_ra(a, (a + 1) % NE, int'($urandom_range(NE - 1)));
            tick();
            check("post_clr_zero", {32'd0, o_nz[WID-1:0]}, 64'd0);
        end

        // Byte merge with same-edge bypass
        wr = 4'hF; wa = 8'd5; i = 32'h11223344; tick();
        wr = 4'b0100; i = 32'hAABBCCDD; set_ra(5, 0, 0); tick();
        check("merge", {32'd0, o[WID-1:0]}, 64'h11BB3344);
        wr = '0;

        // Register 0 of thread 2
        wr = 4'hF; wa = 8'd128; i = 32'hDEADBEEF; set_ra(0, 128, 0); tick();
        check("zb_on", {32'd0, o[2*WID-1:WID]}, 64'd0);
        check("zb_off", {32'd0, o_nz[2*WID-1:WID]}, 64'hDEADBEEF);
        wr = '0;

        // Thread clear with dropped writes and ignored requests
        for (int a = 0; a < NE; a++) begin
            wr = 4'hF; wa = AW'(a); i = $urandom | 32'h1; tick();
        end
        wr = '0; clr_req = 1'b1; clr_tid = 2'd1; tick();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            wr = 4'hF; wa = 8'd70; i = $urandom; clr_req = (n % 7 == 3); clr_tid = 2'd2;
            tick();
            n++;
        end
        check("busy_len_thr", 64'(n), 64'd64);
        wr = '0; clr_req = 1'b0;
        for (int a = 0; a < NE; a++) begin
            set_ra(a, a, a);
            tick();
            if (a >= 64 && a < 128) check("thr_cleared", {32'd0, o_nz[WID-1:0]}, 64'd0);
            else                    check("thr_kept", {63'd0, o_nz[WID-1:0] != 0}, 64'd1);
        end

        // All ports on one address
        wr = 4'hF; wa = 8'd9; i = 32'hCAFEF00D; set_ra(9, 9, 9); tick();
        wr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NRD; k++)
                check("mp_same", {32'd0, o[k*WID +: WID]}, 64'hCAFEF00D);
            tick();
        end

        // Reset in the middle of a thread clear
        clr_req = 1'b1; clr_tid = 2'd2; tick();
        clr_req = 1'b0;
        repeat (30) tick();
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        count_busy("busy_len_restart", NE);
        for (int a = 0; a < NE; a++) begin
            set_ra(a, NE - 1 - a, a);
            tick();
            check("restart_zero", {32'd0, o_nz[WID-1:0]}, 64'd0);
        end

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            wr      = NB'($urandom);
            wa      = AW'($urandom);
            i       = $urandom;
            set_ra(int'($urandom_range(NE - 1)), int'($urandom_range(NE - 1)), int'(wa));
            clr_req = ($urandom_range(39) == 0);
            clr_tid = TW'($urandom);
            rst     = ($urandom_range(499) == 0);
            tick();
        end
        rst = 1'b0; wr = '0; clr_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
